// File: rtl/mmio_pkg.sv
// Shared constants for the Riscv151 memory-mapped I/O block: base address,
// register offsets and status-word bit positions.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;

    localparam logic [7:0]  STATUS      = 8'h00;
    localparam logic [7:0]  RX_DATA     = 8'h04;
    localparam logic [7:0]  TX_DATA     = 8'h08;
    localparam logic [7:0]  CYCLE_CNT   = 8'h10;
    localparam logic [7:0]  INSTRET_CNT = 8'h14;
    localparam logic [7:0]  CNT_RST     = 8'h18;

    localparam int unsigned TX_EMPTY_BIT = 0;
    localparam int unsigned RX_FULL_BIT  = 1;

endpackage

// File: rtl/mmio_ctrl_byte_buf.sv
// One-entry 8-bit holding register. A push is taken only while empty; a push
// wins over a pop in the same cycle so a completed handshake is never lost.
module byte_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic [7:0] data_o
);

    logic       full_q, full_d;
    logic [7:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (pop_i) full_d = 1'b0;
        if (push_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;

endmodule

// File: rtl/mmio_ctrl.sv
// MMIO controller: address decode, UART byte buffers, cycle/instret counters
// and a one-cycle-latency read data register for the memory-stage load mux.
module mmio_ctrl
    import mmio_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        inst_retire,
    output logic [31:0] rdata,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    logic        acc, wr, rd;
    logic [7:0]  off;
    logic        tx_push, tx_pop, tx_full;
    logic        rx_push, rx_pop, rx_full;
    logic [7:0]  rx_byte;
    logic        cnt_clr;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign acc = en & addr[31];
    assign wr  = acc & (|we);
    assign rd  = acc & ~(|we);
    assign off = addr[7:0];

    // Only the low byte selects a register; CLOCK_FREQ is for the UART only.
    assign unused_bits = ^{addr[30:8], wdata[31:8], CLOCK_FREQ};

    assign tx_push       = wr & (off == TX_DATA);
    assign tx_pop        = tx_full & uart_tx_ready;
    assign uart_tx_valid = tx_full;

    byte_buf u_tx_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (tx_push),
        .data_i (wdata[7:0]),
        .pop_i  (tx_pop),
        .full_o (tx_full),
        .data_o (uart_tx_data)
    );

    assign uart_rx_ready = ~rx_full;
    assign rx_push       = uart_rx_valid & ~rx_full;
    assign rx_pop        = rd & (off == RX_DATA);

    byte_buf u_rx_buf (
        .clk    (clk),
        .rst    (rst),
        .push_i (rx_push),
        .data_i (uart_rx_data),
        .pop_i  (rx_pop),
        .full_o (rx_full),
        .data_o (rx_byte)
    );

    assign cnt_clr = wr & (off == CNT_RST);

    always_comb begin
        rd_mux = '0;
        case (off)
            STATUS: begin
                rd_mux[TX_EMPTY_BIT] = ~tx_full;
                rd_mux[RX_FULL_BIT]  = rx_full;
            end
            RX_DATA:     rd_mux[7:0] = rx_byte;
            CYCLE_CNT:   rd_mux      = cycle_q;
            INSTRET_CNT: rd_mux      = instret_q;
            default:     rd_mux      = '0;
        endcase
    end

    always_comb begin
        cycle_d   = cnt_clr ? '0 : cycle_q + 32'd1;
        instret_d = cnt_clr ? '0 : instret_q + {31'd0, inst_retire};
        rdata_d   = rd ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            rdata_q   <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed plus randomized bench for mmio_ctrl against a cycle-level
// behavioural model of the register map, buffers and counters.
module tb_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        inst_retire;
    logic [31:0] rdata;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_rdata, m_cycle, m_instret;
    logic        m_txe, m_rxf;
    logic [7:0]  m_txb, m_rxb;
    int unsigned m_sent_42 = 0;

    always #5 clk = ~clk;

    mmio_ctrl #(.CLOCK_FREQ(50_000_000)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .inst_retire   (inst_retire),
        .rdata         (rdata),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata = 0; m_cycle = 0; m_instret = 0;
        m_txe = 1'b1; m_rxf = 1'b0; m_txb = 0; m_rxb = 0;
    endtask

    // One clock: predict from current inputs, advance, then compare outputs.
    task automatic step();
        logic        acc, wr, rd;
        logic [7:0]  off;
        logic [31:0] n_rdata, n_cycle, n_instret;
        logic        n_txe, n_rxf;
        logic [7:0]  n_txb, n_rxb;
        acc = en && addr[31];
        wr  = acc && (we != 4'd0);
        rd  = acc && (we == 4'd0);
        off = addr[7:0];
        n_rdata = m_rdata; n_txe = m_txe; n_rxf = m_rxf; n_txb = m_txb; n_rxb = m_rxb;
        if (rd) begin
            if (off == 8'h00)      n_rdata = {30'd0, m_rxf, m_txe};
            else if (off == 8'h04) n_rdata = {24'd0, m_rxb};
            else if (off == 8'h10) n_rdata = m_cycle;
            else if (off == 8'h14) n_rdata = m_instret;
            else                   n_rdata = 0;
        end
        if (!m_txe && uart_tx_ready) begin
            n_txe = 1'b1;
            if (m_txb == 8'h42) m_sent_42++;
        end
        if (wr && off == 8'h08 && m_txe) begin
            n_txe = 1'b0;
            n_txb = wdata[7:0];
        end
        if (rd && off == 8'h04) n_rxf = 1'b0;
        if (uart_rx_valid && !m_rxf) begin
            n_rxf = 1'b1;
            n_rxb = uart_rx_data;
        end
        if (wr && off == 8'h18) begin
            n_cycle = 0; n_instret = 0;
        end else begin
            n_cycle = m_cycle + 1;
            n_instret = m_instret + (inst_retire ? 1 : 0);
        end
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin
            m_rdata = n_rdata; m_cycle = n_cycle; m_instret = n_instret;
            m_txe = n_txe; m_rxf = n_rxf; m_txb = n_txb; m_rxb = n_rxb;
        end
        check("rdata", rdata, m_rdata);
        check("tx_valid", {31'd0, uart_tx_valid}, {31'd0, !m_txe});
        check("tx_data", {24'd0, uart_tx_data}, {24'd0, m_txb});
        check("rx_ready", {31'd0, uart_rx_ready}, {31'd0, !m_rxf});
    endtask

    task automatic wr_reg(input logic [7:0] off, input logic [31:0] d);
        en = 1'b1; we = 4'hF; addr = 32'h8000_0000 | {24'd0, off}; wdata = d;
        step();
        en = 1'b0; we = 4'h0;
    endtask

    task automatic rd_reg(input logic [7:0] off);
        en = 1'b1; we = 4'h0; addr = 32'h8000_0000 | {24'd0, off};
        step();
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 0; addr = 0; wdata = 0; inst_retire = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_data = 0; uart_rx_valid = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        check("reset_rdata", rdata, 32'd0);
        check("reset_tx_valid", {31'd0, uart_tx_valid}, 32'd0);

        rd_reg(8'h00);
        check("status_idle", rdata, 32'h1);
        check("rx_ready_idle", {31'd0, uart_rx_ready}, 32'd1);

        wr_reg(8'h08, 32'h0000_0041);
        check("tx_valid_41", {31'd0, uart_tx_valid}, 32'd1);
        check("tx_data_41", {24'd0, uart_tx_data}, 32'h41);
        rd_reg(8'h00);
        check("status_tx_busy", rdata, 32'h0);
        wr_reg(8'h08, 32'h0000_0042);
        check("tx_drop_42", {24'd0, uart_tx_data}, 32'h41);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        rd_reg(8'h00);
        check("status_tx_done", rdata, 32'h1);
        check("no_42_sent", m_sent_42, 32'd0);

        uart_rx_valid = 1'b1; uart_rx_data = 8'h5A;
        step();
        uart_rx_valid = 1'b0;
        rd_reg(8'h00);
        check("status_rx_full", rdata, 32'h3);
        check("rx_ready_full", {31'd0, uart_rx_ready}, 32'd0);
        rd_reg(8'h04);
        check("rx_byte", rdata, 32'h5A);
        rd_reg(8'h00);
        check("status_rx_clear", rdata, 32'h1);

        wr_reg(8'h18, 32'd0);
        for (int unsigned i = 0; i < 10; i++) begin
            inst_retire = (i % 2 == 0) && (i < 8);
            step();
        end
        inst_retire = 1'b0;
        rd_reg(8'h10);
        check("cycle_cnt_10", rdata, 32'd10);
        rd_reg(8'h14);
        check("instret_4", rdata, 32'd4);

        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFF;
        en = 1'b1; we = 4'h0; addr = 32'h8000_0010;
        step();
        check("cycle_max", rdata, 32'hFFFF_FFFF);
        step();
        en = 1'b0;
        check("cycle_wrap", rdata, 32'd0);

        rd_reg(8'h20);
        check("unmapped_rd", rdata, 32'd0);
        rd_reg(8'h08);
        check("wo_rd", rdata, 32'd0);
        en = 1'b1; we = 4'hF; addr = 32'h0000_0008; wdata = 32'h99;
        step();
        en = 1'b0; we = 4'h0;
        check("low_addr_wr", {31'd0, uart_tx_valid}, 32'd0);

        wr_reg(8'h08, 32'h77);
        uart_rx_valid = 1'b1; uart_rx_data = 8'h33;
        step();
        uart_rx_valid = 1'b0;
        rd_reg(8'h10);
        check("pre_rst_tx_valid", {31'd0, uart_tx_valid}, 32'd1);
        check("pre_rst_rx_ready", {31'd0, uart_rx_ready}, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
        check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("rst_rdata", rdata, 32'd0);

        for (int unsigned i = 0; i < 600; i++) begin
            logic [7:0] offs [9];
            offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00};
            offs[8] = 8'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            en = ($urandom_range(0, 2) != 0);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr = {($urandom_range(0, 4) != 0), 23'($urandom), offs[$urandom_range(0, 8)]};
            wdata = $urandom;
            inst_retire = $urandom_range(0, 1);
            uart_tx_ready = ($urandom_range(0, 2) == 0);
            uart_rx_valid = $urandom_range(0, 1);
            uart_rx_data = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
